// File: rtl/lfsr_prng_pkg.sv
// Shared constants and helpers for lfsr_prng: feedback tap masks, the PRESENT sbox,
// and one sbox/permutation layer each, computed on a 64-bit carrier of width w.
package lfsr_prng_pkg;

  // Bit k-1 is set for each 1-indexed tap k.
  localparam logic [63:0] TAPS_W8  = 64'h0000_0000_0000_00B8;
  localparam logic [63:0] TAPS_W16 = 64'h0000_0000_0000_D008;
  localparam logic [63:0] TAPS_W32 = 64'h0000_0000_8020_0003;
  localparam logic [63:0] TAPS_W64 = 64'hD800_0000_0000_0000;

  // Entry n of the sbox sits in bits [4n+3:4n].
  localparam logic [63:0] SBOX_TABLE = 64'h2174_8FE3_DA09_B65C;

  function automatic logic [63:0] tap_mask(input int w);
    logic [63:0] m;
    case (w)
      8:       m = TAPS_W8;
      16:      m = TAPS_W16;
      32:      m = TAPS_W32;
      default: m = TAPS_W64;
    endcase
    return m;
  endfunction

  function automatic logic [63:0] sbox_layer(input logic [63:0] x, input int w);
    logic [63:0] y;
    y = '0;
    for (int n = 0; n < 16; n++) begin
      if (n < w / 4) y[4*n +: 4] = SBOX_TABLE[{x[4*n +: 4], 2'b00} +: 4];
    end
    return y;
  endfunction

  function automatic logic [63:0] perm_layer(input logic [63:0] x, input int w);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) begin
      if (i < w - 1) y[(i * w / 4) % (w - 1)] = x[i];
      else if (i == w - 1) y[i] = x[i];
    end
    return y;
  endfunction

endpackage

// File: rtl/lfsr_prng_round.sv
// One combinational cipher round: PRESENT sbox on every nibble, then the bit permutation.
module lfsr_prng_round
  import lfsr_prng_pkg::*;
#(
  parameter int W = 64
) (
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data
);

  logic [63:0] w_sbox;

  assign w_sbox = sbox_layer(64'(i_data), W);
  assign o_data = W'(perm_layer(w_sbox, W));

endmodule

// File: rtl/lfsr_prng.sv
// Fibonacci LFSR with an optional chain of sbox/permutation rounds on its output.
// Define LFSR_PRNG_ASSERT_EN to enable parameter checks and a nonzero-state assertion.
module lfsr_prng
  import lfsr_prng_pkg::*;
#(
  parameter int unsigned          LfsrWidth    = 64,
  parameter int unsigned          OutWidth     = 8,
  parameter logic [LfsrWidth-1:0] RstVal       = LfsrWidth'(1),
  parameter int unsigned          CipherLayers = 0,
  parameter int unsigned          CipherReg    = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  output logic [OutWidth-1:0] out_o
);

  localparam logic [LfsrWidth-1:0] TAPS = LfsrWidth'(tap_mask(LfsrWidth));

  logic [LfsrWidth-1:0] r_state;
  logic                 w_fb;
  logic [LfsrWidth-1:0] w_chain [CipherLayers+1];
  logic [OutWidth-1:0]  w_func;

  assign w_fb = ^(r_state & TAPS);

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= RstVal;
    else if (en_i) r_state <= {r_state[LfsrWidth-2:0], w_fb};
  end

  // The cipher always sees the pre-step state.
  assign w_chain[0] = r_state;

  for (genvar g = 0; g < CipherLayers; g++) begin : g_round
    lfsr_prng_round #(
      .W(LfsrWidth)
    ) u_round (
      .i_data(w_chain[g]),
      .o_data(w_chain[g+1])
    );
  end

  assign w_func = OutWidth'(w_chain[CipherLayers]);

  if (CipherReg != 0) begin : g_out_reg
    logic [OutWidth-1:0] r_out;
    // Loads every cycle regardless of en_i, so a frozen state settles after one cycle.
    always_ff @(posedge clk_i) begin
      if (rst_i) r_out <= '0;
      else r_out <= w_func;
    end
    assign out_o = r_out;
  end else begin : g_out_comb
    assign out_o = w_func;
  end

`ifdef LFSR_PRNG_ASSERT_EN
  if (RstVal == '0) begin : g_chk_rstval
    $fatal(1, "lfsr_prng: RstVal must be nonzero");
  end
  if (LfsrWidth != 8 && LfsrWidth != 16 && LfsrWidth != 32 && LfsrWidth != 64) begin : g_chk_width
    $fatal(1, "lfsr_prng: LfsrWidth must be 8, 16, 32 or 64");
  end
  if (OutWidth < 1 || OutWidth > LfsrWidth) begin : g_chk_outw
    $fatal(1, "lfsr_prng: OutWidth must be in 1..LfsrWidth");
  end

  a_state_nonzero: assert property (@(posedge clk_i) disable iff (rst_i) r_state != '0)
    else $error("lfsr_prng: LFSR state reached zero");
`else
  // Checks compiled out; datapath unchanged.
`endif

endmodule

// File: tb/tb_lfsr_prng.sv
// Self-checking bench for lfsr_prng: six configurations driven in lockstep and
// compared against a tap-list / nibble-table reference model.
module tb_lfsr_prng;

  logic clk;
  logic rst_i;
  logic en_i;

  logic [7:0]  o0, o1, o2;
  logic [11:0] o3;
  logic [31:0] o4;
  logic [63:0] o5;
  logic [63:0] act [6];

  int n_checks = 0;
  int n_fail   = 0;

  int          p_w  [6] = '{8, 8, 8, 16, 32, 64};
  int          p_cl [6] = '{0, 1, 1, 2, 1, 0};
  int          p_cr [6] = '{0, 0, 1, 1, 0, 1};
  int          p_ow [6] = '{8, 8, 8, 12, 32, 64};
  logic [63:0] p_rv [6] = '{64'h1, 64'h1, 64'h1, 64'hACE1, 64'h1, 64'h0123_4567_89AB_CDEF};
  int          m_sbox [16] = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};

  logic [63:0] m_s [6];
  logic [63:0] m_r [6];

  lfsr_prng #(.LfsrWidth(8), .OutWidth(8), .RstVal(8'h01), .CipherLayers(0), .CipherReg(0))
    dut0 (.clk_i(clk), .rst_i(rst_i), .en_i(en_i), .out_o(o0));
  lfsr_prng #(.LfsrWidth(8), .OutWidth(8), .RstVal(8'h01), .CipherLayers(1), .CipherReg(0))
    dut1 (.clk_i(clk), .rst_i(rst_i), .en_i(en_i), .out_o(o1));
  lfsr_prng #(.LfsrWidth(8), .OutWidth(8), .RstVal(8'h01), .CipherLayers(1), .CipherReg(1))
    dut2 (.clk_i(clk), .rst_i(rst_i), .en_i(en_i), .out_o(o2));
  lfsr_prng #(.LfsrWidth(16), .OutWidth(12), .RstVal(16'hACE1), .CipherLayers(2), .CipherReg(1))
    dut3 (.clk_i(clk), .rst_i(rst_i), .en_i(en_i), .out_o(o3));
  lfsr_prng #(.LfsrWidth(32), .OutWidth(32), .RstVal(32'h1), .CipherLayers(1), .CipherReg(0))
    dut4 (.clk_i(clk), .rst_i(rst_i), .en_i(en_i), .out_o(o4));
  lfsr_prng #(.LfsrWidth(64), .OutWidth(64), .RstVal(64'h0123_4567_89AB_CDEF))
    dut5 (.clk_i(clk), .rst_i(rst_i), .en_i(en_i), .out_o(o5));

  assign act[0] = 64'(o0);
  assign act[1] = 64'(o1);
  assign act[2] = 64'(o2);
  assign act[3] = 64'(o3);
  assign act[4] = 64'(o4);
  assign act[5] = o5;

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [63:0] m_mask(input int w);
    return (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
  endfunction

  function automatic logic [63:0] m_step(input logic [63:0] s, input int w);
    int   taps [4];
    logic fb;
    case (w)
      8:       taps = '{8, 6, 5, 4};
      16:      taps = '{16, 15, 13, 4};
      32:      taps = '{32, 22, 2, 1};
      default: taps = '{64, 63, 61, 60};
    endcase
    fb = 1'b0;
    for (int k = 0; k < 4; k++) fb = fb ^ s[taps[k] - 1];
    return ((s << 1) | 64'(fb)) & m_mask(w);
  endfunction

  function automatic logic [63:0] m_cipher(input logic [63:0] s, input int w, input int rounds);
    logic [63:0] x, t, p;
    int nib, dest;
    x = s;
    for (int r = 0; r < rounds; r++) begin
      t = '0;
      for (int n = 0; n < w / 4; n++) begin
        nib = int'((x >> (4 * n)) & 64'hF);
        t = t | (64'(m_sbox[nib]) << (4 * n));
      end
      p = '0;
      for (int i = 0; i < w; i++) begin
        dest = (i == w - 1) ? i : (i * w / 4) % (w - 1);
        if (t[i]) p = p | (64'd1 << dest);
      end
      x = p;
    end
    return x;
  endfunction

  function automatic logic [63:0] m_func(input int k);
    return m_cipher(m_s[k], p_w[k], p_cl[k]) & m_mask(p_ow[k]);
  endfunction

  function automatic logic [63:0] m_exp(input int k);
    return (p_cr[k] != 0) ? m_r[k] : m_func(k);
  endfunction

  // ---------------- driver ----------------
  task automatic tick(input logic rst, input logic en);
    rst_i = rst;
    en_i  = en;
    @(posedge clk);
    #1;
    for (int k = 0; k < 6; k++) begin
      if (rst) begin
        m_r[k] = '0;
        m_s[k] = p_rv[k];
      end else begin
        m_r[k] = m_func(k);
        if (en) m_s[k] = m_step(m_s[k], p_w[k]);
      end
    end
  endtask

  task automatic do_reset();
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    tick(1'b0, 1'b0);
    n_checks++;
    if (o0 !== 8'h01) begin n_fail++; $display("FAIL reset_dut0 got %h exp 01", o0); end
    n_checks++;
    if (o1 !== 8'hB1) begin n_fail++; $display("FAIL reset_cipher got %h exp b1", o1); end
    // Rewind to observe the registered output in its first post-reset cycle.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      n_checks++;
      if (act[k] !== m_exp(k)) begin
        n_fail++; $display("FAIL reset_model_dut%0d got %h exp %h", k, act[k], m_exp(k));
      end
    end
  endtask

  task automatic test_sequence();
    logic [7:0] exp_seq [4] = '{8'h02, 8'h04, 8'h08, 8'h11};
    do_reset();
    tick(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b1);
      n_checks++;
      if (o0 !== exp_seq[i]) begin
        n_fail++; $display("FAIL sequence_step%0d got %h exp %h", i + 1, o0, exp_seq[i]);
      end
    end
  endtask

  task automatic test_cipher_reg();
    do_reset();
    n_checks++;
    if (o2 !== 8'h00) begin n_fail++; $display("FAIL cipher_reg_first got %h exp 00", o2); end
    tick(1'b0, 1'b1);
    n_checks++;
    if (o2 !== 8'hB1) begin n_fail++; $display("FAIL cipher_reg_second got %h exp b1", o2); end
    n_checks++;
    if (o1 !== m_func(1)) begin n_fail++; $display("FAIL cipher_comb_step got %h exp %h", o1, m_func(1)); end
    tick(1'b0, 1'b1);
    n_checks++;
    if (o2 !== m_exp(2)) begin n_fail++; $display("FAIL cipher_reg_third got %h exp %h", o2, m_exp(2)); end
  endtask

  task automatic test_hold();
    do_reset();
    tick(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b0);
      n_checks++;
      if (o0 !== 8'h08) begin n_fail++; $display("FAIL hold_cycle%0d got %h exp 08", i, o0); end
    end
    n_checks++;
    if (o3 !== m_exp(3)[11:0]) begin n_fail++; $display("FAIL hold_reg_settle got %h exp %h", o3, m_exp(3)); end
    tick(1'b0, 1'b1);
    n_checks++;
    if (o0 !== 8'h11) begin n_fail++; $display("FAIL hold_resume got %h exp 11", o0); end
  endtask

  task automatic test_period();
    bit seen [256];
    for (int v = 0; v < 256; v++) seen[v] = 1'b0;
    do_reset();
    tick(1'b0, 1'b0);
    seen[o0] = 1'b1;
    for (int i = 1; i < 255; i++) begin
      tick(1'b0, 1'b1);
      n_checks++;
      if (o0 === 8'h00 || seen[o0]) begin
        n_fail++; $display("FAIL period_step%0d got %h exp fresh nonzero", i, o0);
      end
      seen[o0] = 1'b1;
    end
    tick(1'b0, 1'b1);
    n_checks++;
    if (o0 !== 8'h01) begin n_fail++; $display("FAIL period_wrap got %h exp 01", o0); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    tick(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b1);
    tick(1'b1, 1'b0);
    n_checks++;
    if (o0 !== 8'h01) begin n_fail++; $display("FAIL reset_mid got %h exp 01", o0); end
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b1);
    n_checks++;
    if (o0 !== 8'h01) begin n_fail++; $display("FAIL reset_with_en got %h exp 01", o0); end
    n_checks++;
    if (o2 !== 8'h00) begin n_fail++; $display("FAIL reset_with_en_reg got %h exp 00", o2); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      tick(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0));
      for (int k = 0; k < 6; k++) begin
        n_checks++;
        if (act[k] !== m_exp(k)) begin
          n_fail++; $display("FAIL random_dut%0d_cyc%0d got %h exp %h", k, i, act[k], m_exp(k));
        end
      end
    end
  endtask

  initial begin
    rst_i = 1'b1;
    en_i  = 1'b0;
    for (int k = 0; k < 6; k++) begin
      m_s[k] = p_rv[k];
      m_r[k] = '0;
    end
    test_reset();
    test_sequence();
    test_cipher_reg();
    test_hold();
    test_period();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lfsr_prng.md
# lfsr_prng

Pseudo-random index generator built from a Fibonacci LFSR followed by optional substitution/permutation cipher layers that break shift-register linearity. It supplies the external arbitration priority (`rr_i`) of the butterfly and Clos TCDM networks, advancing only on cycles where at least one bank handshake completes.

## Interface
- `LfsrWidth`, default 64: state width; supported values are 8, 16, 32 and 64.
- `OutWidth`, default 8: output width, 1..LfsrWidth.
- `RstVal`, default 1: LFSR reset state, LfsrWidth bits, must be nonzero.
- `CipherLayers`, default 0: number of sbox+permutation rounds; 0 bypasses the cipher.
- `CipherReg`, default 1: 1 registers the cipher output; 0 makes it combinational.
- `clk_i`  in  1  clock; one clock domain, rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `en_i`  in  1  advance the LFSR by one step this cycle.
- `out_o`  out  OutWidth  pseudo-random value.

## Operation
- State `s`, LfsrWidth bits. Feedback `fb` = XOR of the tap bits, with taps numbered 1-indexed from bit 0. Next state = `{s[W-2:0], fb}`.
- Taps:
  - W=8: 8,6,5,4
  - W=16: 16,15,13,4
  - W=32: 32,22,2,1
  - W=64: 64,63,61,60
- All tap sets are maximal length, so the period is 2^W−1 and the state is never 0.
- If `en_i`=1 the state steps; otherwise it holds.
- Each cipher round:
  - Sbox: every 4-bit nibble passes through the PRESENT sbox (0..F → C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2).
  - Permutation: bit i moves to (i·W/4) mod (W−1) for i<W−1; bit W−1 stays in place.
- Cipher input is the current state `s`, before any step.
- `out_o` is the low OutWidth bits of the final round. With CipherLayers=0, `out_o` is the low OutWidth bits of `s`.

## Timing
- Reset: `s`=RstVal. The output register (CipherReg=1) resets to 0.
- CipherReg=0: `out_o` = f(`s`) in the same cycle.
- CipherReg=1: the output register loads f(`s`) every cycle, independent of `en_i`, so `out_o` lags the state by one cycle.
  - The first post-reset cycle shows 0.
  - The next cycle shows f(RstVal).
- `en_i` held low: the state freezes. With CipherReg=1, `out_o` settles to f(`s`) after one cycle.
- Reset asserted together with `en_i`: reset wins.
- Reset asserted mid-sequence: the sequence restarts from RstVal on the next edge.

## Configuration
- `LFSR_PRNG_ASSERT_EN` defined, elaboration checks:
  - RstVal ≠ 0
  - LfsrWidth ∈ {8,16,32,64}
  - 1 ≤ OutWidth ≤ LfsrWidth

  Each failure is `$fatal`.
- `LFSR_PRNG_ASSERT_EN` defined, runtime check: assertion that `s` ≠ 0 every cycle out of reset.
- Not defined: no checks; the logic is identical.

## Structure
- Package `lfsr_prng_pkg` holds:
  - the tap-mask constants per width
  - the 16-entry sbox constant
  - functions `sbox_layer(W)` and `perm_layer(W)`
- One sub-module, `lfsr_prng_round`: one combinational sbox+permutation round, instantiated CipherLayers times in a generate chain.

## Test plan
- W=8, RstVal=1, CipherLayers=0, CipherReg=0, OutWidth=8, `en_i`=1 → `out_o` reads 0x01, 0x02, 0x04, 0x08, 0x11 on successive cycles.
- Same config, 255 enabled steps → state returns to 0x01 and no value repeats before then; 0x00 never appears.
- W=8, CipherLayers=1, CipherReg=0, state 0x01 → sbox gives 0xC5, permutation gives `out_o`=0xB1.
- W=8, CipherLayers=1, CipherReg=1 → `out_o`=0x00 in the first post-reset cycle, 0xB1 in the next.
- `en_i` low for 10 cycles after three steps → `out_o` holds 0x08 (CipherLayers=0, CipherReg=0); re-enable resumes at 0x11.
- Assert `rst_i` after 5 steps → next cycle state is 0x01; reset together with `en_i`=1 still yields 0x01.
